// File: rtl/binary_erode_3x3_pkg.sv
// Shared types and helpers for the binary morphology stages.
package binaryz_pkg;

    localparam int DEF_IMAGE_WIDTH  = 276;
    localparam int DEF_IMAGE_HEIGHT = 276;
    localparam int DEF_DATA_WIDTH   = 8;

    localparam logic [DEF_DATA_WIDTH-1:0] FG_VAL = {DEF_DATA_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/binary_erode_3x3_if.sv
// Pixel-in / eroded-pixel-out stream bundle for the erosion stage.
interface binary_erode_3x3_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  pixel_datav_i;
    logic [DATA_WIDTH-1:0] pixel_data_i;
    logic                  erode_datav_o;
    logic [DATA_WIDTH-1:0] erode_data_o;
    logic                  busy_o;
    logic                  frame_err_o;

    modport master (
        output pixel_datav_i, pixel_data_i,
        input  erode_datav_o, erode_data_o, busy_o, frame_err_o
    );

    modport slave (
        input  pixel_datav_i, pixel_data_i,
        output erode_datav_o, erode_data_o, busy_o, frame_err_o
    );
endinterface

// File: rtl/binary_erode_3x3_line_buffer_1b.sv
// 1-bit delay line of exactly DEPTH enabled beats; contents are never cleared.
module line_buffer_1b
    import binaryz_pkg::*;
#(
    parameter int DEPTH = DEF_IMAGE_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic d,
    output logic q
);
    localparam int PW = clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic          mem [DEPTH];
    logic [PW-1:0] ptr;

    // Read-before-write at the same slot yields the bit written DEPTH beats ago.
    assign q = mem[ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     ptr <= '0;
        else if (en)   ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (en) mem[ptr] <= d;
    end
endmodule

// File: rtl/binary_erode_3x3.sv
// Streaming 3x3 binary erosion with out-of-frame neighbours treated as foreground.
module binary_erode_3x3
    import binaryz_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
    input logic               clk_i,
    input logic               rst_i,
    binary_erode_3x3_if.slave bus
);
    localparam int CW = clog2(IMAGE_WIDTH);
    localparam int RW = clog2(IMAGE_HEIGHT + 1);
    localparam int FW = clog2(IMAGE_WIDTH + 3);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [FW-1:0] FL_BEATS = FW'(IMAGE_WIDTH);
    localparam logic [FW-1:0] FL_DONE  = FW'(IMAGE_WIDTH + 2);

    state_t                state, state_nxt;
    logic [CW-1:0]         col, ocol;
    logic [RW-1:0]         row, orow;
    logic [FW-1:0]         fcnt;
    logic                  acc, pix, win_go, win_vld, frame_end;
    logic [2:0][2:0]       win, msk;
    logic                  lb1_q, lb2_q;
    logic                  out_vld, err_q;
    logic [DATA_WIDTH-1:0] out_data;

    line_buffer_1b #(.DEPTH(IMAGE_WIDTH)) u_lb1 (
        .clk_i(clk_i), .rst_i(rst_i), .en(acc), .d(pix), .q(lb1_q)
    );
    line_buffer_1b #(.DEPTH(IMAGE_WIDTH)) u_lb2 (
        .clk_i(clk_i), .rst_i(rst_i), .en(acc), .d(lb1_q), .q(lb2_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // FLUSH issues W+1 synthetic beats, then holds two cycles so the last output drains inside FLUSH.
    always_comb begin
        state_nxt = state;
        acc       = 1'b0;
        pix       = |bus.pixel_data_i;
        win_go    = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                acc = bus.pixel_datav_i;
                if (acc) state_nxt = FILL;
            end
            FILL: begin
                acc    = bus.pixel_datav_i;
                win_go = acc && (row == ROW_ONE) && (col == COL_ONE);
                if (win_go) state_nxt = RUN;
            end
            RUN: begin
                acc    = bus.pixel_datav_i;
                win_go = acc;
                if (acc && (row == ROW_LAST) && (col == COL_LAST)) state_nxt = FLUSH;
            end
            FLUSH: begin
                pix    = 1'b1;
                acc    = (fcnt <= FL_BEATS);
                win_go = acc;
                if (fcnt == FL_DONE) begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window centre is (orow, ocol); frame-edge rows/columns are forced to foreground.
    always_comb begin
        msk = win;
        if (orow == '0)       msk[0] = 3'b111;
        if (orow == ROW_LAST) msk[2] = 3'b111;
        if (ocol == '0)       for (int i = 0; i < 3; i++) msk[i][0] = 1'b1;
        if (ocol == COL_LAST) for (int i = 0; i < 3; i++) msk[i][2] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col      <= '0;
            row      <= '0;
            ocol     <= '0;
            orow     <= '0;
            fcnt     <= '0;
            win      <= '0;
            win_vld  <= 1'b0;
            out_vld  <= 1'b0;
            out_data <= '0;
            err_q    <= 1'b0;
        end else begin
            fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;

            if (frame_end) begin
                col <= '0;
                row <= '0;
            end else if (acc && state != FLUSH) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (acc) begin
                win[0] <= {lb2_q, win[0][2:1]};
                win[1] <= {lb1_q, win[1][2:1]};
                win[2] <= {pix,   win[2][2:1]};
            end

            win_vld <= win_go;
            out_vld <= win_vld;
            if (win_vld) out_data <= (&msk) ? {DATA_WIDTH{1'b1}} : '0;

            if (frame_end) begin
                ocol <= '0;
                orow <= '0;
            end else if (win_vld) begin
                if (ocol == COL_LAST) begin
                    ocol <= '0;
                    orow <= orow + 1'b1;
                end else begin
                    ocol <= ocol + 1'b1;
                end
            end

            if (state == FLUSH && bus.pixel_datav_i) err_q <= 1'b1;
        end
    end

    assign bus.erode_datav_o = out_vld;
    assign bus.erode_data_o  = out_data;
    assign bus.busy_o        = (state != IDLE);
    assign bus.frame_err_o   = err_q;
endmodule

// File: doc/binary_erode_3x3.md
Name: binary_erode_3x3

Overview:
Streaming 3x3 morphological erosion stage. It sits directly downstream of binaryzation and consumes its binaryzation_datav_o/binaryzation_data_o stream in raster order. It emits one eroded pixel per input pixel, with the same frame size. It flushes its own tail, so a frame completes without any trailing input.

Parameters:
IMAGE_WIDTH  276  pixels per line (W), minimum 3
IMAGE_HEIGHT 276  lines per frame (H), minimum 3
DATA_WIDTH   8    pixel width, in and out

Ports:
clk_i          in   1           single clock, rising edge
rst_i          in   1           asynchronous, active-high reset
pixel_datav_i  in   1           input pixel valid; no backpressure
pixel_data_i   in   DATA_WIDTH  binary pixel; nonzero = foreground
erode_datav_o  out  1           output pixel valid
erode_data_o   out  DATA_WIDTH  all-ones = foreground, zero = background
busy_o         out  1           high from first accepted pixel until last flush beat
frame_err_o    out  1           sticky; set if pixel_datav_i is high during FLUSH

Behaviour:
- Reset (async, immediate):
  - erode_datav_o = 0, erode_data_o = 0, busy_o = 0, frame_err_o = 0.
  - State = IDLE; col/row/input/output counters = 0.
  - Line-buffer contents are not cleared.
- Input:
  - Each cycle with pixel_datav_i = 1 is one beat k = r*W + c.
  - Gaps (valid low) are allowed anywhere and stall the pipeline; no state advances.
  - Stored bit = (pixel_data_i != 0).
- Storage: two W-deep 1-bit line buffers (rows r-1 and r-2) plus a 3x3 window register.
- Function:
  - out(r,c) = AND of the 3x3 neighbourhood centred at (r,c).
  - Neighbours outside the frame (row < 0, row >= H, col < 0, col >= W) count as foreground.
  - This masking also hides stale line-buffer data from a previous frame.
- Latency:
  - Output j = (r,c) is registered on the clock after input beat j+W+1 is accepted.
  - Outputs therefore start 1 clock after beat W+1 (the (W+2)th pixel).
  - Output gaps mirror input gaps.
- FSM:
  - IDLE -> FILL on the first valid beat; busy_o rises with that beat.
  - FILL -> RUN when beat W+1 is accepted.
  - RUN -> FLUSH on acceptance of beat W*H-1; that beat still produces output W*H-W-2 on the next clock.
  - FLUSH: the block self-generates W+1 beats on consecutive cycles, one output each, for j = W*H-W-1 .. W*H-1. Row H and column padding are forced to foreground.
  - FLUSH -> IDLE after the final output; busy_o falls the same clock erode_datav_o drops.
- Output count: exactly W*H beats per frame.
- Counter widths: col = clog2(W), row = clog2(H+1). Column wraps at W-1 -> 0 and increments row.
- Boundaries:
  - Input during FLUSH: the pixel is dropped and frame_err_o is set. frame_err_o clears only on reset.
  - A valid beat in the same cycle as the final FLUSH output is also dropped and flagged.
  - The first beat accepted in IDLE starts a fresh frame.
  - rst_i mid-frame: outputs go to 0 immediately. The next frame after release is processed correctly, with no residue.
  - W = 3 or H = 3 must work.

Decomposition:
- Shared package binaryz_pkg:
  - state enum IDLE/FILL/RUN/FLUSH
  - FG_VAL = {DATA_WIDTH{1'b1}}
  - default IMAGE_WIDTH/IMAGE_HEIGHT
  - clog2 helper
- One sub-module: line_buffer_1b (parameter DEPTH). It is a 1-bit W-deep delay line with an enable, instantiated twice.

Test Plan:
1. W=8, H=6, all 0xFF, continuous valid -> 48 outputs all 0xFF. First erode_datav_o 1 clock after the 10th input beat; last 9 outputs on consecutive cycles after input ends; busy_o low after.
2. All 0xFF except (2,3) = 0x00 -> zeros exactly at rows 1..3, cols 2..4 (9 pixels); other 39 = 0xFF.
3. All 0xFF except corner (0,7) = 0x00 -> zeros only at (0,6), (0,7), (1,6), (1,7), confirming foreground padding.
4. Scenario 2 frame with pixel_datav_i alternating 1/0 and input 0x01 in place of 0xFF -> identical output values. Count 48; flush still 9 back-to-back beats.
5. Valid asserted for 2 cycles during FLUSH -> frame_err_o = 1 and stays 1. Output count still 48, values unchanged.
6. rst_i pulsed after 20 input beats -> all outputs 0 asynchronously. A following full scenario-2 frame produces the scenario-2 result exactly.
